exe_muldiv: RTL and testbench

- Multi-cycle RV64M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Consumes operands held by the decode/execute pipeline register and iterates one bit per cycle.
- Drives a stall back to that register's enable and to the upstream stages while iterating.
- Pulses a one-cycle done carrying the result and destination register to the execute/memory path.

---
 rtl/exe_muldiv.sv | 217 +++++++++++++++++++++
 tb/tb_exe_muldiv.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage: one bit per cycle,
// shift-add multiply and restoring divide on operand magnitudes, sign fix-up at the end.
module exe_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] rs1val,
    input  logic [XLEN-1:0] rs2val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] hi_q, hi_d;
    logic [63:0] lo_q, lo_d;
    logic [63:0] opb_q, opb_d;
    logic [2:0]  f3_q, f3_d;
    logic        word_q, word_d;
    logic        prod_neg_q, prod_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic [63:0] result_q, result_d;

    logic        is_div;
    logic        signed_a;
    logic        signed_b;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_mag;
    logic [63:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic [63:0] special_res;

    logic [64:0]  mul_sum;
    logic [64:0]  div_sh;
    logic         div_ge;
    logic [63:0]  div_diff;
    logic [63:0]  step_hi;
    logic [63:0]  step_lo;
    logic [127:0] prod_fix;
    logic [63:0]  quot_fix;
    logic [63:0]  rem_fix;
    logic [63:0]  div_val;
    logic [63:0]  calc_res;

    // Operand decode for the op being offered this cycle; W variants extend the low word.
    always_comb begin
        is_div   = funct3[2];
        signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        a_ext    = word ? {{32{signed_a & rs1val[31]}}, rs1val[31:0]} : rs1val;
        b_ext    = word ? {{32{signed_b & rs2val[31]}}, rs2val[31:0]} : rs2val;
        a_neg    = signed_a & a_ext[63];
        b_neg    = signed_b & b_ext[63];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = is_div && (b_ext == 64'd0);
        div_ovf  = is_div && signed_a && (b_ext == 64'hFFFF_FFFF_FFFF_FFFF) &&
                   (a_ext == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special_res = 64'd0;
        if (div_zero) begin
            if (funct3[1]) begin
                special_res = word ? {{32{rs1val[31]}}, rs1val[31:0]} : rs1val;
            end else begin
                special_res = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else if (!funct3[1]) begin
            special_res = a_ext;
        end
    end

    // One iteration step; multiply shifts right through {hi,lo}, divide shifts left.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : 64'd0)};
        div_sh   = {hi_q, lo_q[63]};
        div_ge   = div_sh >= {1'b0, opb_q};
        div_diff = div_sh[63:0] - opb_q;
        if (f3_q[2]) begin
            step_hi = div_ge ? div_diff : div_sh[63:0];
            step_lo = {lo_q[62:0], div_ge};
        end else begin
            step_hi = mul_sum[64:1];
            step_lo = {mul_sum[0], lo_q[63:1]};
        end
    end

    // Sign correction and result selection, used only on the final iteration.
    // A 32-bit product lands 32 bits up in {hi,lo}, hence prod_fix[63:32] for MULW.
    always_comb begin
        prod_fix = prod_neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quot_fix = prod_neg_q ? -step_lo : step_lo;
        rem_fix  = rem_neg_q ? -step_hi : step_hi;
        div_val  = f3_q[1] ? rem_fix : quot_fix;
        if (f3_q[2]) begin
            calc_res = word_q ? {{32{div_val[31]}}, div_val[31:0]} : div_val;
        end else if (word_q) begin
            calc_res = {{32{prod_fix[63]}}, prod_fix[63:32]};
        end else if (f3_q[1:0] == 2'd0) begin
            calc_res = prod_fix[63:0];
        end else begin
            calc_res = prod_fix[127:64];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        f3_d       = f3_q;
        word_d     = word_q;
        prod_neg_d = prod_neg_q;
        rem_neg_d  = rem_neg_q;
        rd_d       = rd_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                CALC: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d  = DONE;
                        result_d = calc_res;
                        rd_out_d = rd_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    if (start) begin
                        f3_d       = funct3;
                        word_d     = word;
                        rd_d       = rd_in;
                        prod_neg_d = a_neg ^ b_neg;
                        rem_neg_d  = a_neg;
                        hi_d       = 64'd0;
                        if (is_div) begin
                            lo_d  = word ? {a_mag[31:0], 32'd0} : a_mag;
                            opb_d = b_mag;
                        end else begin
                            lo_d  = b_mag;
                            opb_d = a_mag;
                        end
                        if (div_zero || div_ovf) begin
                            state_d  = DONE;
                            cnt_d    = 7'd0;
                            result_d = special_res;
                            rd_out_d = rd_in;
                        end else begin
                            state_d = CALC;
                            cnt_d   = word ? 7'd32 : 7'd64;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 7'd0;
            hi_q       <= 64'd0;
            lo_q       <= 64'd0;
            opb_q      <= 64'd0;
            f3_q       <= 3'd0;
            word_q     <= 1'b0;
            prod_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            rd_q       <= 5'd0;
            rd_out_q   <= 5'd0;
            result_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opb_q      <= opb_d;
            f3_q       <= f3_d;
            word_q     <= word_d;
            prod_neg_q <= prod_neg_d;
            rem_neg_q  <= rem_neg_d;
            rd_q       <= rd_d;
            rd_out_q   <= rd_out_d;
            result_q   <= result_d;
        end
    end

    assign stall  = (start && (state_q != CALC) && !flush) || (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: the driver pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares on done.
module tb_exe_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic        word;
    logic [63:0] rs1val;
    logic [63:0] rs2val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_exp;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          calc_lo = 1;
    int          calc_hi = 0;
    int          free_cyc = 0;
    logic        mon_en = 1'b0;
    logic        m_in_calc;
    logic [63:0] last_res = 64'd0;
    logic [4:0]  last_rd = 5'd0;

    exe_muldiv #(.XLEN(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .word   (word),
        .rs1val (rs1val),
        .rs2val (rs2val),
        .rd_in  (rd_in),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Divide by zero and signed overflow finish in one cycle.
    function automatic logic refSpecial(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        logic zero;
        logic ovf;
        if (!f3[2]) return 1'b0;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        return zero || ovf;
    endfunction

    function automatic logic [63:0] refResult(input logic [2:0] f3, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic signed [63:0]  sa, sb, sq;
        logic signed [31:0]  sa32, sb32, sq32;
        logic [31:0]         r32;
        logic                ovf;
        if (w) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            ovf  = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
            case (f3)
                3'd4: begin
                    if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF;
                    else if (ovf) r32 = a[31:0];
                    else begin sq32 = sa32 / sb32; r32 = sq32; end
                end
                3'd5: r32 = (b[31:0] == 32'd0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
                3'd6: begin
                    if (b[31:0] == 32'd0) r32 = a[31:0];
                    else if (ovf) r32 = 32'd0;
                    else begin sq32 = sa32 % sb32; r32 = sq32; end
                end
                3'd7: r32 = (b[31:0] == 32'd0) ? a[31:0] : a[31:0] % b[31:0];
                default: r32 = a[31:0] * b[31:0];
            endcase
            return {{32{r32[31]}}, r32};
        end
        sa  = a;
        sb  = b;
        ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        case (f3)
            3'd0: return a * b;
            3'd1: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return sp[127:64]; end
            3'd2: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); return sp[127:64]; end
            3'd3: begin up = {64'd0, a} * {64'd0, b}; return up[127:64]; end
            3'd4: begin
                if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (ovf) return a;
                sq = sa / sb;
                return sq;
            end
            3'd5: return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: begin
                if (b == 64'd0) return a;
                if (ovf) return 64'd0;
                sq = sa % sb;
                return sq;
            end
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            5: return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one op as soon as the unit can take it (idle or its DONE cycle).
    task automatic applyStimulus(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        exp_t e;
        int   lat;
        while (cyc < free_cyc) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        funct3 = f3;
        word   = w;
        rs1val = a;
        rs2val = b;
        rd_in  = rd;
        lat    = refSpecial(f3, w, a, b) ? 1 : (w ? 33 : 65);
        e.res  = refResult(f3, w, a, b);
        e.rd   = rd;
        e.due  = cyc + lat;
        sb_q.push_back(e);
        calc_lo  = cyc + 1;
        calc_hi  = cyc + lat - 1;
        free_cyc = cyc + lat;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        word   = 1'($urandom);
        rs1val = {$urandom, $urandom};
        rs2val = {$urandom, $urandom};
        rd_in  = 5'($urandom);
    endtask

    // A start offered while the unit is busy must be ignored.
    task automatic pokeStart();
        start  = 1'b1;
        funct3 = 3'($urandom);
        rs1val = {$urandom, $urandom};
        rs2val = {$urandom, $urandom};
        rd_in  = 5'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            m_in_calc = (cyc >= calc_lo) && (cyc <= calc_hi);
            checkOutput("stall", 64'(stall), 64'(m_in_calc || (start && !flush)));
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                m_exp = sb_q.pop_front();
                checkOutput("done_pulse", 64'(done), 64'd1);
                checkOutput("result", result, m_exp.res);
                checkOutput("rd_out", 64'(rd_out), 64'(m_exp.rd));
                last_res = m_exp.res;
                last_rd  = m_exp.rd;
            end else begin
                checkOutput("no_done", 64'(done), 64'd0);
                checkOutput("held_result", result, last_res);
                checkOutput("held_rd", 64'(rd_out), 64'(last_rd));
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic        w;
        int          k;
        reset  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        word   = 1'b0;
        rs1val = 64'd0;
        rs2val = 64'd0;
        rd_in  = 5'd0;

        idleCycles(3);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_rd", 64'(rd_out), 64'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        idleCycles(2);

        applyStimulus(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
        applyStimulus(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6);
        idleCycles(5);
        pokeStart();
        applyStimulus(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
        idleCycles(2);
        applyStimulus(3'd4, 1'b0, 64'd100, 64'd0, 5'd8);
        applyStimulus(3'd6, 1'b0, 64'd100, 64'd0, 5'd9);
        applyStimulus(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
        idleCycles(1);
        applyStimulus(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd11);
        applyStimulus(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd12);
        idleCycles(1);
        applyStimulus(3'd5, 1'b0, 64'd1000, 64'd7, 5'd13);
        applyStimulus(3'd7, 1'b0, 64'd1000, 64'd7, 5'd14);

        // Squash an op at its tenth iteration.
        applyStimulus(3'd0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd15);
        k = cyc - 1;
        while (cyc < k + 10) idleCycles(1);
        flush = 1'b1;
        void'(sb_q.pop_back());
        calc_hi  = cyc;
        free_cyc = cyc + 1;
        idleCycles(1);
        flush = 1'b0;
        idleCycles(2);
        start = 1'b1;
        flush = 1'b1;
        idleCycles(1);
        start = 1'b0;
        flush = 1'b0;
        idleCycles(3);

        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom);
            if (w && f3 != 3'd0) f3 = 3'($urandom_range(4, 7));
            applyStimulus(f3, w, randOperand(), randOperand(), 5'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                while (cyc < free_cyc) idleCycles(1);
                idleCycles($urandom_range(0, 2));
            end
        end
        while (cyc < free_cyc) idleCycles(1);
        idleCycles(1);

        // Reset in the middle of an iteration clears everything at once.
        applyStimulus(3'd5, 1'b0, {$urandom, $urandom}, {$urandom, $urandom} | 64'd1, 5'd20);
        idleCycles(20);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        checkOutput("midrst_stall", 64'(stall), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_result", result, 64'd0);
        checkOutput("midrst_rd", 64'(rd_out), 64'd0);
        sb_q.delete();
        last_res = 64'd0;
        last_rd  = 5'd0;
        calc_lo  = 1;
        calc_hi  = 0;
        free_cyc = 0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("midrst_hold_done", 64'(done), 64'd0);
        end
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        idleCycles(2);
        applyStimulus(3'd0, 1'b1, 64'h0000_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 5'd21);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        checkOutput("drain", 64'(sb_q.size()), 64'd0);
        idleCycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
